// File: rtl/drum_hit_sequencer_if.sv
// Control/sample bundle between the drum voice top level and the hit sequencer.
// The sequencer side uses the slave modport; the driver side uses master.
interface drum_hit_sequencer_if #(
    parameter int STEPS   = 16,
    parameter int TEMPO_W = 24,
    parameter int DECAY_W = 16
);
    localparam int SW = $clog2(STEPS);

    logic               run;
    logic [STEPS-1:0]   pattern;
    logic [TEMPO_W-1:0] tempo_div;
    logic [DECAY_W-1:0] decay_div;
    logic               trig;
    logic [7:0]         sample_in;
    logic [7:0]         sample_out;
    logic [7:0]         env;
    logic [SW-1:0]      step_idx;
    logic               step_tick;
    logic               voice_reset;
    logic               busy;

    modport master (
        output run, pattern, tempo_div, decay_div, trig, sample_in,
        input  sample_out, env, step_idx, step_tick, voice_reset, busy
    );

    modport slave (
        input  run, pattern, tempo_div, decay_div, trig, sample_in,
        output sample_out, env, step_idx, step_tick, voice_reset, busy
    );
endinterface

// File: rtl/drum_hit_sequencer.sv
// 16-step drum hit sequencer with an ATTACK/DECAY amplitude envelope that
// scales the offset-binary voice sample before it leaves the chip.
module drum_hit_sequencer #(
    parameter int STEPS   = 16,
    parameter int TEMPO_W = 24,
    parameter int DECAY_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    drum_hit_sequencer_if.slave   bus
);
    localparam int SW = $clog2(STEPS);

    localparam logic [SW-1:0]      STEP_ZERO  = SW'(0);
    localparam logic [SW-1:0]      STEP_ONE   = SW'(1);
    localparam logic [TEMPO_W-1:0] TEMPO_ZERO = TEMPO_W'(0);
    localparam logic [TEMPO_W-1:0] TEMPO_ONE  = TEMPO_W'(1);
    localparam logic [DECAY_W-1:0] DECAY_ZERO = DECAY_W'(0);
    localparam logic [DECAY_W-1:0] DECAY_ONE  = DECAY_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ATTACK = 2'd1,
        ST_DECAY  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TEMPO_W-1:0] r_tempo_cnt;
    logic [TEMPO_W-1:0] w_tempo_nxt;
    logic [SW-1:0]      r_step_idx;
    logic [SW-1:0]      w_step_nxt;
    logic [7:0]         r_env;
    logic [7:0]         w_env_nxt;
    logic [DECAY_W-1:0] r_decay_cnt;
    logic [DECAY_W-1:0] w_decay_nxt;
    logic [7:0]         r_sample_out;
    logic               r_step_tick;
    logic               r_voice_reset;

    logic               w_tick;
    logic               w_hit;
    logic [8:0]         w_att_sum;
    logic [15:0]        w_s_ext;
    logic [15:0]        w_e_ext;
    logic signed [15:0] w_prod;
    logic [7:0]         w_sample_nxt;

    // A tick fires on every counter wrap, including the very first run=1 clock.
    assign w_tick = bus.run & (r_tempo_cnt == TEMPO_ZERO);
    // Trig and a pattern hit in the same cycle collapse into a single hit.
    assign w_hit  = (w_tick & bus.pattern[r_step_idx]) | bus.trig;

    assign w_att_sum = {1'b0, r_env} + 9'd32;

    // Low 16 bits of the two's-complement product are exact because |s*env| < 2^15.
    assign w_s_ext      = {8'd0, bus.sample_in} - 16'd128;
    assign w_e_ext      = {8'd0, r_env};
    assign w_prod       = $signed(w_s_ext * w_e_ext);
    assign w_sample_nxt = 8'(w_prod >>> 8) + 8'h80;

    // Tempo divider and step pointer next-state; stopping rewinds both.
    always_comb begin
        w_tempo_nxt = r_tempo_cnt;
        w_step_nxt  = r_step_idx;
        if (!bus.run) begin
            w_tempo_nxt = TEMPO_ZERO;
            w_step_nxt  = STEP_ZERO;
        end else begin
            // >= keeps the counter bounded if tempo_div is lowered below it.
            if (r_tempo_cnt >= bus.tempo_div) begin
                w_tempo_nxt = TEMPO_ZERO;
            end else begin
                w_tempo_nxt = r_tempo_cnt + TEMPO_ONE;
            end
            if (w_tick) begin
                w_step_nxt = r_step_idx + STEP_ONE;
            end else begin
                w_step_nxt = r_step_idx;
            end
        end
    end

    // Tempo divider and step pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tempo_cnt <= TEMPO_ZERO;
            r_step_idx  <= STEP_ZERO;
        end else begin
            r_tempo_cnt <= w_tempo_nxt;
            r_step_idx  <= w_step_nxt;
        end
    end

    // Envelope FSM next-state: a hit always restarts ATTACK from the current level.
    always_comb begin
        w_state_nxt = r_state;
        w_env_nxt   = r_env;
        w_decay_nxt = r_decay_cnt;
        if (w_hit) begin
            w_state_nxt = ST_ATTACK;
            w_env_nxt   = r_env;
            w_decay_nxt = DECAY_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_env_nxt   = 8'd0;
                    w_decay_nxt = DECAY_ZERO;
                end
                ST_ATTACK: begin
                    w_decay_nxt = DECAY_ZERO;
                    if (w_att_sum >= 9'd255) begin
                        w_env_nxt   = 8'd255;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_env_nxt = w_att_sum[7:0];
                    end
                end
                ST_DECAY: begin
                    if (r_env == 8'd0) begin
                        w_state_nxt = ST_IDLE;
                        w_decay_nxt = DECAY_ZERO;
                    end else if (r_decay_cnt >= bus.decay_div) begin
                        w_env_nxt   = r_env - 8'd1;
                        w_decay_nxt = DECAY_ZERO;
                        if (r_env == 8'd1) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DECAY;
                        end
                    end else begin
                        w_decay_nxt = r_decay_cnt + DECAY_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_env_nxt   = 8'd0;
                    w_decay_nxt = DECAY_ZERO;
                end
            endcase
        end
    end

    // Envelope FSM state, level and decay prescaler registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_env       <= 8'd0;
            r_decay_cnt <= DECAY_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_env       <= w_env_nxt;
            r_decay_cnt <= w_decay_nxt;
        end
    end

    // Registered pulses and the enveloped sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_step_tick   <= 1'b0;
            r_voice_reset <= 1'b0;
            r_sample_out  <= 8'h80;
        end else begin
            r_step_tick   <= w_tick;
            r_voice_reset <= w_hit;
            r_sample_out  <= w_sample_nxt;
        end
    end

    assign bus.sample_out  = r_sample_out;
    assign bus.env         = r_env;
    assign bus.step_idx    = r_step_idx;
    assign bus.step_tick   = r_step_tick;
    assign bus.voice_reset = r_voice_reset;
    assign bus.busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_drum_hit_sequencer.sv
// Directed bench for drum_hit_sequencer: tempo walk, envelope shape,
// retrigger, sample scaling and asynchronous reset mid-operation.
module tb_drum_hit_sequencer;
    localparam int STEPS   = 16;
    localparam int TEMPO_W = 24;
    localparam int DECAY_W = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    drum_hit_sequencer_if #(.STEPS(STEPS), .TEMPO_W(TEMPO_W), .DECAY_W(DECAY_W)) bus ();

    drum_hit_sequencer #(.STEPS(STEPS), .TEMPO_W(TEMPO_W), .DECAY_W(DECAY_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic test_reset;
        reset_n       = 1'b0;
        bus.run       = 1'b0;
        bus.pattern   = 16'h0000;
        bus.tempo_div = 24'd0;
        bus.decay_div = 16'd0;
        bus.trig      = 1'b0;
        bus.sample_in = 8'hFF;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.sample_out !== 8'h80) begin n_errors++; $display("FAIL rst_sample: got %0h want 80", bus.sample_out); end
        n_checks++; if (bus.env !== 8'd0) begin n_errors++; $display("FAIL rst_env: got %0d want 0", bus.env); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        n_checks++; if (bus.step_idx !== 4'd0) begin n_errors++; $display("FAIL rst_step: got %0d want 0", bus.step_idx); end
        n_checks++; if ({bus.step_tick, bus.voice_reset} !== 2'b00) begin n_errors++; $display("FAIL rst_pulses: got %b want 00", {bus.step_tick, bus.voice_reset}); end
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.sample_out !== 8'h80) begin n_errors++; $display("FAIL idle_sample: got %0h want 80", bus.sample_out); end
            n_checks++; if ({bus.step_tick, bus.voice_reset, bus.busy} !== 3'b000) begin n_errors++; $display("FAIL idle_pulses: got %b want 000", {bus.step_tick, bus.voice_reset, bus.busy}); end
        end
    endtask

    task automatic test_tempo;
        bit       exp_tick;
        bit       exp_vr;
        int       played;
        bus.tempo_div = 24'd3;
        bus.decay_div = 16'd0;
        bus.pattern   = 16'h0001;
        bus.run       = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            exp_tick = ((k - 1) % 4) == 0;
            played   = ((k - 1) / 4) % 16;
            exp_vr   = exp_tick && (played == 0);
            n_checks++; if (bus.step_tick !== exp_tick) begin n_errors++; $display("FAIL tempo_tick k=%0d: got %0b want %0b", k, bus.step_tick, exp_tick); end
            n_checks++; if (bus.voice_reset !== exp_vr) begin n_errors++; $display("FAIL tempo_vr k=%0d: got %0b want %0b", k, bus.voice_reset, exp_vr); end
            n_checks++; if (bus.step_idx !== 4'((((k - 1) / 4) + 1) % 16)) begin n_errors++; $display("FAIL tempo_idx k=%0d: got %0d want %0d", k, bus.step_idx, (((k - 1) / 4) + 1) % 16); end
        end
        bus.run = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.step_idx !== 4'd0) begin n_errors++; $display("FAIL stop_idx: got %0d want 0", bus.step_idx); end
        @(negedge clk);
        n_checks++; if (bus.step_tick !== 1'b0) begin n_errors++; $display("FAIL stop_tick: got %0b want 0", bus.step_tick); end
        for (int i = 0; i < 600 && bus.busy; i++) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL tempo_idle_timeout: got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_envelope;
        int exp_env;
        bus.decay_div = 16'd1;
        bus.sample_in = 8'h80;
        bus.trig      = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        n_checks++; if ({bus.voice_reset, bus.busy} !== 2'b11) begin n_errors++; $display("FAIL env_entry: got vr/busy=%b want 11", {bus.voice_reset, bus.busy}); end
        n_checks++; if (bus.env !== 8'd0) begin n_errors++; $display("FAIL env_entry_lvl: got %0d want 0", bus.env); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_env = (32 * k > 255) ? 255 : 32 * k;
            n_checks++; if (bus.env !== 8'(exp_env)) begin n_errors++; $display("FAIL attack k=%0d: got %0d want %0d", k, bus.env, exp_env); end
        end
        n_checks++; if (bus.voice_reset !== 1'b0) begin n_errors++; $display("FAIL env_vr_once: got %0b want 0", bus.voice_reset); end
        for (int j = 1; j <= 510; j++) begin
            @(negedge clk);
            exp_env = 255 - j / 2;
            n_checks++; if (bus.env !== 8'(exp_env)) begin n_errors++; $display("FAIL decay j=%0d: got %0d want %0d", j, bus.env, exp_env); end
            n_checks++; if (bus.busy !== (j < 510)) begin n_errors++; $display("FAIL decay_busy j=%0d: got %0b want %0b", j, bus.busy, (j < 510)); end
        end
    endtask

    task automatic test_retrigger;
        logic [7:0] exp_att [5] = '{8'd132, 8'd164, 8'd196, 8'd228, 8'd255};
        bus.decay_div = 16'd1;
        bus.trig      = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        repeat (8 + 311) @(negedge clk);
        n_checks++; if (bus.env !== 8'd100) begin n_errors++; $display("FAIL retrig_pre: got %0d want 100", bus.env); end
        // The next edge would be a decay terminal count; the hit must win.
        bus.trig = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        n_checks++; if (bus.env !== 8'd100) begin n_errors++; $display("FAIL retrig_hold: got %0d want 100", bus.env); end
        n_checks++; if (bus.voice_reset !== 1'b1) begin n_errors++; $display("FAIL retrig_vr: got %0b want 1", bus.voice_reset); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (bus.env !== exp_att[k]) begin n_errors++; $display("FAIL retrig_att k=%0d: got %0d want %0d", k, bus.env, exp_att[k]); end
            n_checks++; if (bus.voice_reset !== 1'b0) begin n_errors++; $display("FAIL retrig_vr_single k=%0d: got %0b want 0", k, bus.voice_reset); end
        end
        bus.decay_div = 16'd0;
        bus.tempo_div = 24'd3;
        bus.pattern   = 16'h0001;
        bus.run       = 1'b1;
        bus.trig      = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        n_checks++; if ({bus.voice_reset, bus.step_tick} !== 2'b11) begin n_errors++; $display("FAIL coinc_pulse: got vr/tick=%b want 11", {bus.voice_reset, bus.step_tick}); end
        @(negedge clk);
        n_checks++; if (bus.voice_reset !== 1'b0) begin n_errors++; $display("FAIL coinc_single: got %0b want 0", bus.voice_reset); end
        bus.run = 1'b0;
        for (int i = 0; i < 600 && bus.busy; i++) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL retrig_idle_timeout: got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_scaling;
        logic [7:0] in_128  [2] = '{8'hC0, 8'h3F};
        logic [7:0] exp_128 [2] = '{8'hA0, 8'h5F};
        logic [7:0] in_255  [3] = '{8'hFF, 8'h00, 8'h80};
        logic [7:0] exp_255 [3] = '{8'hFE, 8'h00, 8'h80};
        bus.decay_div = 16'd0;
        for (int v = 0; v < 2; v++) begin
            bus.trig = 1'b1;
            @(negedge clk);
            bus.trig = 1'b0;
            repeat (4) @(negedge clk);
            n_checks++; if (bus.env !== 8'd128) begin n_errors++; $display("FAIL scale_env128 v=%0d: got %0d want 128", v, bus.env); end
            bus.sample_in = in_128[v];
            @(negedge clk);
            n_checks++; if (bus.sample_out !== exp_128[v]) begin n_errors++; $display("FAIL scale128 in=%0h: got %0h want %0h", in_128[v], bus.sample_out, exp_128[v]); end
            bus.sample_in = 8'h80;
            for (int i = 0; i < 600 && bus.busy; i++) @(negedge clk);
            n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL scale_idle_timeout: got busy=%0b want 0", bus.busy); end
        end
        bus.decay_div = 16'hFFFF;
        bus.trig      = 1'b1;
        @(negedge clk);
        bus.trig = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (bus.env !== 8'd255) begin n_errors++; $display("FAIL scale_env255: got %0d want 255", bus.env); end
        for (int v = 0; v < 3; v++) begin
            bus.sample_in = in_255[v];
            @(negedge clk);
            n_checks++; if (bus.sample_out !== exp_255[v]) begin n_errors++; $display("FAIL scale255 in=%0h: got %0h want %0h", in_255[v], bus.sample_out, exp_255[v]); end
        end
    endtask

    task automatic test_reset_mid;
        bus.decay_div = 16'd0;
        bus.sample_in = 8'h80;
        for (int i = 0; i < 600 && bus.busy; i++) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL mid_idle_timeout: got busy=%0b want 0", bus.busy); end
        bus.sample_in = 8'hFF;
        bus.tempo_div = 24'd3;
        bus.pattern   = 16'h0020;
        bus.run       = 1'b1;
        repeat (23) @(negedge clk);
        n_checks++; if (bus.env !== 8'd64) begin n_errors++; $display("FAIL mid_env: got %0d want 64", bus.env); end
        n_checks++; if (bus.step_idx !== 4'd6) begin n_errors++; $display("FAIL mid_step: got %0d want 6", bus.step_idx); end
        n_checks++; if (bus.sample_out !== 8'h8F) begin n_errors++; $display("FAIL mid_sample: got %0h want 8f", bus.sample_out); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.env !== 8'd0) begin n_errors++; $display("FAIL async_env: got %0d want 0", bus.env); end
        n_checks++; if (bus.step_idx !== 4'd0) begin n_errors++; $display("FAIL async_step: got %0d want 0", bus.step_idx); end
        n_checks++; if (bus.sample_out !== 8'h80) begin n_errors++; $display("FAIL async_sample: got %0h want 80", bus.sample_out); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL async_busy: got %0b want 0", bus.busy); end
        bus.pattern = 16'h0001;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.step_tick, bus.voice_reset} !== 2'b11) begin n_errors++; $display("FAIL post_rst_first: got tick/vr=%b want 11", {bus.step_tick, bus.voice_reset}); end
        n_checks++; if (bus.step_idx !== 4'd1) begin n_errors++; $display("FAIL post_rst_step: got %0d want 1", bus.step_idx); end
        bus.run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tempo();
        test_envelope();
        test_retrigger();
        test_scaling();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/drum_hit_sequencer.md
Name: drum_hit_sequencer

Overview:
- Step sequencer and amplitude-envelope controller for the drum voice datapath (sine_gen + noise_gen).
- Walks a 16-step hit pattern at a programmable tempo. On each hit it pulses a phase-restart to the voice generators and runs an ATTACK/DECAY envelope.
- Scales the offset-binary voice sample by the envelope before it drives GPIO.

Parameters:
- STEPS, 16, number of pattern steps (power of two).
- TEMPO_W, 24, width of the tempo divider.
- DECAY_W, 16, width of the decay-rate divider.

Ports:
- clk  in  1  system clock (MAX10_CLK1_50 at top level).
- reset_n  in  1  asynchronous reset, active-low.
- run  in  1  level; 1 = sequencer advancing, 0 = stopped and rewound.
- pattern  in  STEPS  hit bit per step; bit i plays on step i.
- tempo_div  in  TEMPO_W  clocks per step minus 1.
- decay_div  in  DECAY_W  clocks per envelope decrement minus 1.
- trig  in  1  manual hit, one-cycle pulse.
- sample_in  in  8  voice sample, offset binary (0x80 = silence).
- sample_out  out  8  enveloped sample, offset binary, registered.
- env  out  8  current envelope level.
- step_idx  out  $clog2(STEPS)  step that will play on the next tick.
- step_tick  out  1  registered one-cycle pulse per step.
- voice_reset  out  1  registered one-cycle active-high pulse per hit, to the voice generators' reset.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous): tempo_cnt=0, step_idx=0, env=0, decay_cnt=0, state=IDLE, sample_out=0x80, step_tick=0, voice_reset=0, busy=0.
- Tempo, run=0: tempo_cnt=0, step_idx=0, no ticks. The envelope keeps running.
- Tempo, run=1: internal tick = (tempo_cnt==0).
  - tempo_cnt increments and wraps to 0 after reaching tempo_div.
  - On a tick, step_idx advances, wrapping from STEPS-1 to 0.
  - The first tick occurs on the first clock with run=1 and plays step 0.
  - tempo_div=0 gives a tick every clock.
- hit = (tick && pattern[step_idx]) || trig. A simultaneous trig and pattern hit counts as one hit.
- step_tick is asserted the cycle after a tick. voice_reset is asserted the cycle after a hit.
- FSM states: IDLE, ATTACK, DECAY.
  - A hit in any state moves to ATTACK next cycle with env retained (retrigger does not zero env) and decay_cnt cleared.
  - ATTACK, each clock: env <= min(env+32, 255). When the sum is >=255, env=255 and the next state is DECAY.
  - Attack from 0 takes 8 cycles: 32, 64, ..., 224, 255.
  - DECAY: decay_cnt counts 0..decay_div. On the terminal count, env <= env-1 and decay_cnt <= 0.
  - When env reaches 0 in DECAY, the next state is IDLE.
  - Full decay from 255 takes 255*(decay_div+1) clocks.
  - IDLE: env holds 0.
  - A hit in the same cycle as a decay terminal count: the hit wins and no decrement occurs.
- decay_div and tempo_div changes take effect at the next counter compare. No counter restart.
- Output arithmetic:
  - s = {1'b0,sample_in} - 128, 9-bit signed.
  - p = s * {1'b0,env}, 17-bit signed.
  - q = p >>> 8 (floor). Range is -128..126.
  - sample_out <= q[7:0] + 8'h80, registered, 1-cycle latency from sample_in/env.
  - env=0 yields 0x80. No saturation is needed.
- Reset asserted mid-envelope or mid-step returns everything to reset values immediately. After release, sequencing starts from step 0 on the first run=1 clock.

Test Plan:
- Reset/idle: reset_n=0, then release with run=0, sample_in=0xFF → sample_out=0x80, env=0, busy=0, no step_tick/voice_reset.
- Tempo: tempo_div=3, pattern=16'h0001, run=1 for 80 clocks → step_tick every 4 clocks; voice_reset only on the step-0 tick; step_idx wraps 15→0 after 64 clocks.
- Envelope: trig pulse with decay_div=1 → env 32..224,255 over 8 cycles; then -1 every 2 clocks; busy drops when env=0 at 8+510 clocks after entry to ATTACK.
- Retrigger: trig while in DECAY at env=100 → ATTACK from 100: 132, 164, ..., 255; exactly one voice_reset pulse per trig; trig coincident with a pattern hit → a single pulse.
- Scaling: env held at 255, sample_in=0xFF → 0xFE; sample_in=0x00 → 0x00; sample_in=0x80 → 0x80; env=128, sample_in=0xC0 → 0xA0; env=128, sample_in=0x3F → 0x5F (floor).
- Reset mid-operation: assert reset_n=0 during ATTACK at step 5 → env=0, step_idx=0, sample_out=0x80 within the same cycle; after release with run=1 → first tick plays step 0.
